// File: rtl/noc_input_buffer_if.sv
// Handshake bundle between one router input port, its upstream link, the arbiter and the crossbar.
// slave = the input buffer, master = whatever drives it.
interface noc_input_buffer_if #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [FLIT_W-1:0] in_flit;
  logic              arb_req;
  logic [ADDR_W-1:0] arb_dest_x;
  logic [ADDR_W-1:0] arb_dest_y;
  logic              arb_grant;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic              out_ready;
  logic              err_drop;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  in_valid, in_flit, arb_grant, out_ready,
    output in_ready, arb_req, arb_dest_x, arb_dest_y, out_valid, out_flit, err_drop, occupancy
  );

  modport master (
    output in_valid, in_flit, arb_grant, out_ready,
    input  in_ready, arb_req, arb_dest_x, arb_dest_y, out_valid, out_flit, err_drop, occupancy
  );
endinterface

// File: rtl/noc_input_buffer.sv
// Per-port flit FIFO plus IDLE/REQ/XFER packet sequencer feeding the router arbiter and crossbar.
// The head flit's destination is latched on entry to REQ and held until the tail has left.
module noc_input_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  noc_input_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = PTR_W + 1;
  localparam int HEAD_B = FLIT_W - 1;
  localparam int TAIL_B = FLIT_W - 2;

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

  state_e                       state_q, state_d;
  logic [DEPTH-1:0][FLIT_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]             occ_q, occ_d;
  logic [ADDR_W-1:0]            dest_x_q, dest_x_d, dest_y_q, dest_y_d;
  logic                         arb_req_q, arb_req_d;
  logic                         err_drop_q, err_drop_d;
  logic                         empty, push, pop;

  assign empty          = (occ_q == '0);
  // Gated by rst_n so upstream sees back-pressure for the whole reset window.
  assign bus.in_ready   = rst_n && (occ_q != OCC_W'(DEPTH));
  assign push           = bus.in_valid && bus.in_ready;
  assign bus.out_valid  = (state_q == XFER) && !empty;
  assign bus.out_flit   = mem_q[rd_ptr_q];
  assign bus.arb_req    = arb_req_q;
  assign bus.arb_dest_x = dest_x_q;
  assign bus.arb_dest_y = dest_y_q;
  assign bus.err_drop   = err_drop_q;
  assign bus.occupancy  = occ_q;

  always_comb begin
    state_d    = state_q;
    dest_x_d   = dest_x_q;
    dest_y_d   = dest_y_q;
    arb_req_d  = arb_req_q;
    err_drop_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: if (!empty) begin
        if (mem_q[rd_ptr_q][HEAD_B]) begin
          state_d   = REQ;
          arb_req_d = 1'b1;
          dest_x_d  = mem_q[rd_ptr_q][ADDR_W-1:0];
          dest_y_d  = mem_q[rd_ptr_q][2*ADDR_W-1:ADDR_W];
        end else begin
          // Body/tail with no head in front of it: discard so the port cannot wedge.
          pop        = 1'b1;
          err_drop_d = 1'b1;
        end
      end
      REQ: if (bus.arb_grant) begin
        state_d   = XFER;
        arb_req_d = 1'b0;
      end
      XFER: if (bus.out_valid && bus.out_ready) begin
        pop = 1'b1;
        if (mem_q[rd_ptr_q][TAIL_B]) state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        arb_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_flit;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      dest_x_q   <= '0;
      dest_y_q   <= '0;
      arb_req_q  <= 1'b0;
      err_drop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      dest_x_q   <= dest_x_d;
      dest_y_q   <= dest_y_d;
      arb_req_q  <= arb_req_d;
      err_drop_q <= err_drop_d;
    end
  end
endmodule
